// File: rtl/minimig_bus_pkg.sv
// Shared chip-bus definitions: grant bit positions, slot classes and slot owners.
package minimig_bus_pkg;

    localparam int NUM_GNT      = 7;
    localparam int GNT_REF      = 0;
    localparam int GNT_DSK      = 1;
    localparam int GNT_AUD      = 2;
    localparam int GNT_SPR      = 3;
    localparam int GNT_BPL      = 4;
    localparam int GNT_COP      = 5;
    localparam int GNT_BLT      = 6;
    localparam int LINE_LEN_DEF = 227;

    typedef enum logic [2:0] {
        SLOT_NONE,
        SLOT_REF,
        SLOT_DSK,
        SLOT_AUD,
        SLOT_SPR
    } slot_cls_e;

    typedef enum logic [2:0] {
        OWN_CPU,
        OWN_REF,
        OWN_DSK,
        OWN_AUD,
        OWN_SPR,
        OWN_BPL,
        OWN_COP,
        OWN_BLT
    } slot_owner_e;

    // The CPU owns a slot implicitly, so it maps to an empty grant vector.
    function automatic logic [NUM_GNT-1:0] owner_to_grant(input slot_owner_e own);
        logic [NUM_GNT-1:0] g;
        g = '0;
        case (own)
            OWN_REF: g[GNT_REF] = 1'b1;
            OWN_DSK: g[GNT_DSK] = 1'b1;
            OWN_AUD: g[GNT_AUD] = 1'b1;
            OWN_SPR: g[GNT_SPR] = 1'b1;
            OWN_BPL: g[GNT_BPL] = 1'b1;
            OWN_COP: g[GNT_COP] = 1'b1;
            OWN_BLT: g[GNT_BLT] = 1'b1;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/chip_slot_scheduler_table.sv
// Combinational map from slot index to its fixed-slot class and audio channel.
module chip_slot_table
    import minimig_bus_pkg::*;
#(
    parameter int REF_START = 1,
    parameter int DSK_START = 9,
    parameter int AUD_START = 15,
    parameter int SPR_START = 23
) (
    input  logic [7:0] hpos_i,
    output slot_cls_e  cls_o,
    output logic [1:0] aud_chan_o
);

    localparam logic [7:0] AUD_ST = 8'(AUD_START);

    logic [7:0] aud_off;
    int         h;

    assign aud_off = hpos_i - AUD_ST;
    assign h       = int'(hpos_i);

    // Fixed slots occupy odd positions only; each channel owns every other slot.
    always_comb begin
        cls_o      = SLOT_NONE;
        aud_chan_o = 2'd0;
        if (hpos_i[0]) begin
            if (h >= REF_START && h <= REF_START + 6) begin
                cls_o = SLOT_REF;
            end else if (h >= DSK_START && h <= DSK_START + 4) begin
                cls_o = SLOT_DSK;
            end else if (h >= AUD_START && h <= AUD_START + 6) begin
                cls_o      = SLOT_AUD;
                aud_chan_o = 2'(aud_off >> 1);
            end else if (h >= SPR_START && h <= SPR_START + 30) begin
                cls_o = SLOT_SPR;
            end
        end
    end

endmodule

// File: rtl/chip_slot_scheduler.sv
// Per-slot chip-bus owner selection: fixed DMA slots, then bitplane/copper/blitter, CPU gets the rest.
module chip_slot_scheduler
    import minimig_bus_pkg::*;
#(
    parameter int LINE_LEN  = LINE_LEN_DEF,
    parameter int REF_START = 1,
    parameter int DSK_START = 9,
    parameter int AUD_START = 15,
    parameter int SPR_START = 23
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               slot_en,
    input  logic               en_dsk,
    input  logic               dsk_wr,
    input  logic [3:0]         en_aud,
    input  logic               en_spr,
    input  logic               bpl_req,
    input  logic               cop_req,
    input  logic               blt_req,
    input  logic               blt_wr,
    input  logic               blt_nasty,
    input  logic               cpu_req,
    output logic [7:0]         hpos,
    output logic               eol,
    output logic [NUM_GNT-1:0] grant,
    output logic [1:0]         aud_chan,
    output logic               dma,
    output logic               dmawr,
    output logic               dmapri
);

    localparam logic [7:0] HPOS_MAX = 8'(LINE_LEN - 1);

    logic [7:0]         hpos_q, hpos_d;
    logic [NUM_GNT-1:0] grant_q, grant_d;
    logic [1:0]         aud_chan_q, aud_chan_d;
    logic [1:0]         blt_cnt_q, blt_cnt_d;
    logic               dmawr_q, dmawr_d;
    logic               dmapri_q, eol_q;
    logic               blt_yield;
    slot_cls_e          cls;
    logic [1:0]         tbl_chan;
    slot_owner_e        owner;

    // Outputs describe the slot being entered, so the table looks at the next position.
    assign hpos_d = (hpos_q == HPOS_MAX) ? 8'd0 : hpos_q + 8'd1;

    chip_slot_table #(
        .REF_START(REF_START),
        .DSK_START(DSK_START),
        .AUD_START(AUD_START),
        .SPR_START(SPR_START)
    ) u_table (
        .hpos_i    (hpos_d),
        .cls_o     (cls),
        .aud_chan_o(tbl_chan)
    );

    assign blt_yield = !blt_nasty && cpu_req && (blt_cnt_q == 2'd3);

    always_comb begin
        owner = OWN_CPU;
        case (cls)
            SLOT_REF: owner = OWN_REF;
            SLOT_DSK: if (en_dsk) owner = OWN_DSK;
            SLOT_AUD: if (en_aud[tbl_chan]) owner = OWN_AUD;
            SLOT_SPR: if (en_spr) owner = OWN_SPR;
            default:  owner = OWN_CPU;
        endcase
        if (owner == OWN_CPU) begin
            if (bpl_req)                       owner = OWN_BPL;
            else if (cop_req && !hpos_d[0])    owner = OWN_COP;
            else if (blt_req && !blt_yield)    owner = OWN_BLT;
        end
    end

    assign grant_d    = owner_to_grant(owner);
    assign aud_chan_d = (owner == OWN_AUD) ? tbl_chan : 2'd0;
    assign dmawr_d    = (grant_d[GNT_DSK] & dsk_wr) | (grant_d[GNT_BLT] & blt_wr);

    // Run length of consecutive blitter slots while the CPU waits; fixed DMA slots hold it.
    always_comb begin
        blt_cnt_d = blt_cnt_q;
        if (grant_d == '0 || !cpu_req) blt_cnt_d = 2'd0;
        else if (owner == OWN_BLT)     blt_cnt_d = blt_cnt_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpos_q     <= 8'd0;
            grant_q    <= '0;
            aud_chan_q <= 2'd0;
            blt_cnt_q  <= 2'd0;
            dmawr_q    <= 1'b0;
            dmapri_q   <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            eol_q <= slot_en && (hpos_d == 8'd0);
            if (slot_en) begin
                hpos_q     <= hpos_d;
                grant_q    <= grant_d;
                aud_chan_q <= aud_chan_d;
                blt_cnt_q  <= blt_cnt_d;
                dmawr_q    <= dmawr_d;
                dmapri_q   <= blt_nasty & blt_req;
            end
        end
    end

    assign hpos     = hpos_q;
    assign eol      = eol_q;
    assign grant    = grant_q;
    assign aud_chan = aud_chan_q;
    assign dma      = |grant_q;
    assign dmawr    = dmawr_q;
    assign dmapri   = dmapri_q;

endmodule

// File: tb/tb_chip_slot_scheduler.sv
// Scoreboard bench for chip_slot_scheduler: directed slot sequences with hand-written expectations.
module tb_chip_slot_scheduler;

    logic       clk = 1'b0;
    logic       reset_n, slot_en, en_dsk, dsk_wr, en_spr;
    logic [3:0] en_aud;
    logic       bpl_req, cop_req, blt_req, blt_wr, blt_nasty, cpu_req;
    logic [7:0] hpos;
    logic       eol, dma, dmawr, dmapri;
    logic [6:0] grant;
    logic [1:0] aud_chan;

    typedef struct packed {
        logic [7:0] hpos;
        logic [6:0] grant;
        logic       chk_chan;
        logic [1:0] chan;
        logic       dmawr;
        logic       dmapri;
        logic       eol;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_hpos = 0;
    logic burst = 1'b0;

    chip_slot_scheduler dut (
        .clk(clk), .reset_n(reset_n), .slot_en(slot_en), .en_dsk(en_dsk), .dsk_wr(dsk_wr),
        .en_aud(en_aud), .en_spr(en_spr), .bpl_req(bpl_req), .cop_req(cop_req),
        .blt_req(blt_req), .blt_wr(blt_wr), .blt_nasty(blt_nasty), .cpu_req(cpu_req),
        .hpos(hpos), .eol(eol), .grant(grant), .aud_chan(aud_chan), .dma(dma),
        .dmawr(dmawr), .dmapri(dmapri)
    );

    always #5 clk = ~clk;

    function automatic int nh();
        return (tb_hpos == 226) ? 0 : tb_hpos + 1;
    endfunction

    // Empty line: only refresh at 1/3/5/7.
    function automatic logic [6:0] idle_g(input int h);
        return (h % 2 == 1 && h <= 7) ? 7'h01 : 7'h00;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [6:0] g, input logic cc, input logic [1:0] ch,
                        input logic wr, input logic pri);
        exp_t e;
        tb_hpos    = nh();
        e.hpos     = 8'(tb_hpos);
        e.grant    = g;
        e.chk_chan = cc;
        e.chan     = ch;
        e.dmawr    = wr;
        e.dmapri   = pri;
        e.eol      = (tb_hpos == 0);
        slot_en    = 1'b1;
        expq.push_back(e);
        @(negedge clk);
        if (!burst) begin
            slot_en = 1'b0;
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        if (reset_n && slot_en) begin
            exp_t e;
            #1;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_slot: got hpos=%0d with no expectation queued", hpos);
            end else begin
                e = expq.pop_front();
                if (hpos !== e.hpos || grant !== e.grant || dma !== (|e.grant) ||
                    dmawr !== e.dmawr || dmapri !== e.dmapri || eol !== e.eol ||
                    (e.chk_chan && aud_chan !== e.chan)) begin
                    errors++;
                    $display("FAIL slot%0d: got hpos=%0d grant=%b dma=%b wr=%b pri=%b eol=%b chan=%0d expected hpos=%0d grant=%b wr=%b pri=%b eol=%b chan=%0d",
                             e.hpos, hpos, grant, dma, dmawr, dmapri, eol, aud_chan,
                             e.hpos, e.grant, e.dmawr, e.dmapri, e.eol, e.chan);
                end
            end
        end
    end

    initial begin
        int h;
        logic [6:0] g;
        reset_n = 1'b0; slot_en = 1'b0; en_dsk = 1'b0; dsk_wr = 1'b0; en_aud = 4'd0;
        en_spr = 1'b0; bpl_req = 1'b0; cop_req = 1'b0; blt_req = 1'b0; blt_wr = 1'b0;
        blt_nasty = 1'b0; cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hpos", hpos, 0);
        check("rst_grant", grant, 0);
        check("rst_eol", eol, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Run to hpos=100 with copper + nasty blitter pending at the last slot.
        for (int i = 1; i < 100; i++) begin
            h = nh();
            step(idle_g(h), 1'b0, 2'd0, 1'b0, 1'b0);
        end
        cop_req = 1'b1; blt_req = 1'b1; blt_nasty = 1'b1;
        step(7'h20, 1'b0, 2'd0, 1'b0, 1'b1);
        cop_req = 1'b0; blt_req = 1'b0; blt_nasty = 1'b0;

        reset_n = 1'b0;
        #1;
        check("midrst_hpos", hpos, 0);
        check("midrst_grant", grant, 0);
        check("midrst_dma", dma, 0);
        check("midrst_dmapri", dmapri, 0);
        check("midrst_chan", aud_chan, 0);
        check("midrst_dmawr", dmawr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tb_hpos = 0;
        @(negedge clk);

        // Fixed slots with disk (write) and audio channels 0 and 2.
        en_dsk = 1'b1; dsk_wr = 1'b1; en_aud = 4'b0101;
        for (int i = 1; i <= 59; i++) begin
            h = nh();
            case (h)
                1, 3, 5, 7: step(7'h01, 1'b0, 2'd0, 1'b0, 1'b0);
                9, 11, 13:  step(7'h02, 1'b0, 2'd0, 1'b1, 1'b0);
                15:         step(7'h04, 1'b1, 2'd0, 1'b0, 1'b0);
                19:         step(7'h04, 1'b1, 2'd2, 1'b0, 1'b0);
                default:    step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
            endcase
        end
        en_dsk = 1'b0; dsk_wr = 1'b0; en_aud = 4'd0;

        // Blitter yields every 4th slot to a waiting CPU.
        blt_req = 1'b1; cpu_req = 1'b1;
        for (int i = 60; i <= 67; i++) begin
            h = nh();
            step((h == 63 || h == 67) ? 7'h00 : 7'h40, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        blt_req = 1'b0;
        step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // Nasty blitter never yields; direction follows blt_wr.
        blt_nasty = 1'b1; blt_req = 1'b1;
        for (int i = 70; i <= 77; i++) begin
            h = nh();
            blt_wr = (h < 74);
            step(7'h40, 1'b0, 2'd0, blt_wr, 1'b1);
        end
        blt_nasty = 1'b0; blt_req = 1'b0; cpu_req = 1'b0; blt_wr = 1'b0;
        step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // Copper parity with bitplane override and blitter fill, slot_en held high.
        cop_req = 1'b1; burst = 1'b1;
        for (int i = 80; i <= 99; i++) begin
            h = nh();
            bpl_req = (h >= 90 && h <= 93);
            blt_req = (h >= 94 && h <= 97);
            if (bpl_req)         g = 7'h10;
            else if (h % 2 == 0) g = 7'h20;
            else if (blt_req)    g = 7'h40;
            else                 g = 7'h00;
            step(g, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        burst = 1'b0; cop_req = 1'b0; bpl_req = 1'b0; blt_req = 1'b0;

        for (int i = 100; i <= 226; i++) step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        step(7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        check("eol_single_cycle", eol, 0);

        // Next line: fixed refresh/sprite slots beat bitplane, disabled ones fall through.
        bpl_req = 1'b1; en_spr = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            h = nh();
            if (h % 2 == 1 && h <= 7)        g = 7'h01;
            else if (h % 2 == 1 && h >= 23)  g = 7'h08;
            else                             g = 7'h10;
            step(g, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        bpl_req = 1'b0; en_spr = 1'b0;

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
